l2_flush_walker: RTL and testbench
==================================

L2_FLUSH_WALKER -- requirements
Module: l2_flush_walker

Interface
REQ-001 SHALL have parameter AWTH, default 3, meaning the line index width; the walker covers 2**AWTH lines.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush_req_i  input  1  flush start request, sampled in IDLE only.
REQ-005 SHALL have port flush_busy_o  output  1  high in every state except IDLE.
REQ-006 SHALL have port flush_done_o  output  1  one-cycle completion pulse.
REQ-007 SHALL have port dirty_raddr_o  output  AWTH  read index to the dirty-bit register array.
REQ-008 SHALL have port dirty_rdata_i  input  1  dirty bit at dirty_raddr_o, combinational same-cycle return.
REQ-009 SHALL have port dirty_clr_o  output  1  clear strobe to the array's reset-write enable.
REQ-010 SHALL have port dirty_caddr_o  output  AWTH  index to clear.
REQ-011 SHALL have port wb_req_o  output  1  writeback request valid.
REQ-012 SHALL have port wb_addr_o  output  AWTH  line index of the writeback.
REQ-013 SHALL have port wb_ack_i  input  1  writeback accepted; a transfer completes on a cycle with wb_req_o=1 and wb_ack_i=1.
REQ-014 SHALL have port wb_cnt_o  output  AWTH+1  number of writebacks issued by the most recent flush.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, WB, CLEAR, DONE with one registered line index idx.
REQ-016 IDLE: flush_req_i=1 -> SCAN, idx<=0, wb_cnt_o<=0; otherwise stay in IDLE.
REQ-017 SCAN: dirty_raddr_o=idx; dirty_rdata_i=1 -> WB; dirty_rdata_i=0 and idx=2**AWTH-1 -> DONE; dirty_rdata_i=0 otherwise -> SCAN with idx+1.
REQ-018 WB: wb_req_o=1, wb_addr_o=idx, both held stable until wb_ack_i=1; the handshake cycle -> CLEAR and wb_cnt_o+1.
REQ-019 CLEAR: dirty_clr_o=1 and dirty_caddr_o=idx for exactly one cycle; idx=2**AWTH-1 -> DONE, else -> SCAN with idx+1.
REQ-020 DONE: flush_done_o=1 for one cycle -> IDLE.
REQ-021 wb_ack_i outside WB SHALL be ignored.
REQ-022 flush_req_i outside IDLE SHALL be ignored; no queuing.
REQ-023 idx SHALL never wrap; reaching the last index always ends the walk through DONE.
REQ-024 wb_cnt_o SHALL hold its value from DONE until the next accepted flush_req_i.
REQ-025 Latency SHALL be N+2 cycles from the request edge to the flush_done_o pulse for an all-clean array, with N=2**AWTH.
REQ-026 Each dirty line SHALL add 2 cycles plus the WB wait cycles to that latency.
REQ-027 dirty_raddr_o SHALL equal idx in all states.
REQ-028 When not in WB, wb_req_o SHALL be 0 and wb_addr_o SHALL equal idx.
REQ-029 When not in CLEAR, dirty_clr_o SHALL be 0 and dirty_caddr_o SHALL equal idx.

Reset
REQ-030 While rst_i=0: state=IDLE, idx=0, wb_cnt_o=0.
REQ-031 While rst_i=0: flush_busy_o, flush_done_o, wb_req_o and dirty_clr_o SHALL all be 0.
REQ-032 Reset asserted mid-flush SHALL abort immediately; any pending wb_req_o drops without a handshake and no clear is issued.
REQ-033 After rst_i rises, the block SHALL wait in IDLE for a new flush_req_i.

Verification
REQ-034 AWTH=3, all bits clean, flush_req_i pulse -> 8 SCAN cycles, flush_done_o 10 cycles after the request edge, wb_cnt_o=0, no wb_req_o.
REQ-035 Dirty bits {2,7}, wb_ack_i tied 1 -> wb_addr_o=2 then 7, dirty_clr_o at 2 then 7, flush_done_o at cycle 14, wb_cnt_o=2.
REQ-036 Dirty bit {0}, wb_ack_i held low 5 cycles -> wb_req_o and wb_addr_o=0 stable for 6 cycles, then one clear at 0.
REQ-037 Second flush_req_i and stray wb_ack_i during a busy walk -> no effect on state, idx or wb_cnt_o.
REQ-038 rst_i low while in WB at idx=4 -> all outputs 0 asynchronously, no clear at 4; a later flush restarts at idx=0.
REQ-039 All 8 lines dirty, wb_ack_i tied 1 -> wb_cnt_o=8, last clear at 7, no wrap to 0 before DONE.

Source files
------------

// File: rtl/l2_flush_walker.sv
// Walks every line index of an L2 dirty-bit array, issues a writeback for each
// dirty line, clears its bit, and pulses done once the last index has been visited.
module l2_flush_walker #(
  parameter int AWTH = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_req_i,
  output logic            flush_busy_o,
  output logic            flush_done_o,
  output logic [AWTH-1:0] dirty_raddr_o,
  input  logic            dirty_rdata_i,
  output logic            dirty_clr_o,
  output logic [AWTH-1:0] dirty_caddr_o,
  output logic            wb_req_o,
  output logic [AWTH-1:0] wb_addr_o,
  input  logic            wb_ack_i,
  output logic [AWTH:0]   wb_cnt_o,
  output logic [2:0]      state_o
);

  // Writeback handshake: wb_req_o/wb_addr_o are held stable from the first WB
  // cycle until a cycle with wb_req_o=1 and wb_ack_i=1; wb_ack_i is ignored
  // whenever wb_req_o is low.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    WB    = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [AWTH-1:0] IDX_LAST = {AWTH{1'b1}};
  localparam logic [AWTH-1:0] IDX_ONE  = {{(AWTH-1){1'b0}}, 1'b1};
  localparam logic [AWTH:0]   CNT_ONE  = {{AWTH{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [AWTH-1:0] idx_q, idx_d;
  logic [AWTH:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    flush_busy_o = (state_q != IDLE);
    flush_done_o = 1'b0;
    wb_req_o     = 1'b0;
    dirty_clr_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (dirty_rdata_i) begin
          state_d = WB;
        end else if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      WB: begin
        wb_req_o = 1'b1;
        if (wb_ack_i) begin
          state_d = CLEAR;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      CLEAR: begin
        dirty_clr_o = 1'b1;
        // The last index always exits through DONE so idx never wraps.
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          state_d = SCAN;
          idx_d   = idx_q + IDX_ONE;
        end
      end
      DONE: begin
        flush_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dirty_raddr_o = idx_q;
  assign dirty_caddr_o = idx_q;
  assign wb_addr_o     = idx_q;
  assign wb_cnt_o      = cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_l2_flush_walker.sv
// Bench for l2_flush_walker: a dirty-array/writeback environment, a per-cycle
// trace model built from the walk rules, and directed plus randomized flushes.
module tb_l2_flush_walker;

  localparam int AWTH = 3;
  localparam int N    = 1 << AWTH;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            flush_req_i;
  logic            flush_busy_o;
  logic            flush_done_o;
  logic [AWTH-1:0] dirty_raddr_o;
  logic            dirty_rdata_i;
  logic            dirty_clr_o;
  logic [AWTH-1:0] dirty_caddr_o;
  logic            wb_req_o;
  logic [AWTH-1:0] wb_addr_o;
  logic            wb_ack_i;
  logic [AWTH:0]   wb_cnt_o;
  logic [2:0]      dut_state;

  l2_flush_walker #(.AWTH(AWTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_req_i   (flush_req_i),
    .flush_busy_o  (flush_busy_o),
    .flush_done_o  (flush_done_o),
    .dirty_raddr_o (dirty_raddr_o),
    .dirty_rdata_i (dirty_rdata_i),
    .dirty_clr_o   (dirty_clr_o),
    .dirty_caddr_o (dirty_caddr_o),
    .wb_req_o      (wb_req_o),
    .wb_addr_o     (wb_addr_o),
    .wb_ack_i      (wb_ack_i),
    .wb_cnt_o      (wb_cnt_o),
    .state_o       (dut_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- environment ----------------
  logic [N-1:0] dirty_mem = '0;
  logic [N-1:0] load_val  = '0;
  logic         load_en   = 1'b0;
  logic         req_pulse = 1'b0;
  logic         req_noise = 1'b0;
  logic         stray_ack = 1'b0;
  logic         noise_en  = 1'b0;
  int           waits[N];
  int           wait_ctr  = 0;
  int           hs_log[$];
  int           clr_log[$];

  assign dirty_rdata_i = dirty_mem[dirty_raddr_o];
  assign flush_req_i   = req_pulse | (req_noise & flush_busy_o);

  always_comb begin
    wb_ack_i = stray_ack;
    if (wb_req_o) wb_ack_i = (wait_ctr >= waits[wb_addr_o]);
  end

  always @(posedge clk_i) begin
    if (!rst_i) wait_ctr <= 0;
    else if (wb_req_o && wb_ack_i) begin
      wait_ctr <= 0;
      hs_log.push_back(int'(wb_addr_o));
    end else if (wb_req_o) wait_ctr <= wait_ctr + 1;
    if (load_en) dirty_mem <= load_val;
    else if (dirty_clr_o) begin
      dirty_mem[dirty_caddr_o] <= 1'b0;
      clr_log.push_back(int'(dirty_caddr_o));
    end
  end

  always @(negedge clk_i) begin
    stray_ack = noise_en && ($urandom_range(1, 0) == 1);
    req_noise = noise_en && ($urandom_range(1, 0) == 1);
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic            busy;
    logic            done;
    logic            wbreq;
    logic            clr;
    logic [AWTH-1:0] raddr;
    logic [AWTH-1:0] wbaddr;
    logic [AWTH-1:0] caddr;
    logic [AWTH:0]   cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t act_o, exp_o;
  int   n_pass  = 0;
  int   n_total = 0;
  int   last_idx = 0;
  int   last_cnt = 0;

  task automatic check_eq(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic obs_t mk(input logic busy, input logic done, input logic wbreq,
                              input logic clr, input int i, input int c);
    obs_t o;
    o.busy   = busy;
    o.done   = done;
    o.wbreq  = wbreq;
    o.clr    = clr;
    o.raddr  = i[AWTH-1:0];
    o.wbaddr = i[AWTH-1:0];
    o.caddr  = i[AWTH-1:0];
    o.cnt    = c[AWTH:0];
    return o;
  endfunction

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_o        = exp_q.pop_front();
      act_o.busy   = flush_busy_o;
      act_o.done   = flush_done_o;
      act_o.wbreq  = wb_req_o;
      act_o.clr    = dirty_clr_o;
      act_o.raddr  = dirty_raddr_o;
      act_o.wbaddr = wb_addr_o;
      act_o.caddr  = dirty_caddr_o;
      act_o.cnt    = wb_cnt_o;
      check_eq("trace{busy,done,wbreq,clr,raddr,wbaddr,caddr,cnt}",
               longint'(act_o), longint'(exp_o));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain(input int bound);
    int ok;
    ok = 0;
    for (int k = 0; k < bound && ok == 0; k++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0) ok = 1;
    end
    if (ok == 0) begin
      check_eq("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic push_idle(input int m);
    for (int k = 0; k < m; k++) exp_q.push_back(mk(0, 0, 0, 0, last_idx, last_cnt));
    wait_drain(m + 5);
  endtask

  // Builds the expected cycle trace from the dirty pattern and ack waits, then
  // issues a one-cycle request; lat is the negedge count from the drive edge to done.
  task automatic run_flush(input logic [N-1:0] d, input int minw, input int maxw,
                           output int lat, output int exp_lat);
    int c;
    @(posedge clk_i); #1;
    for (int i = 0; i < N; i++) waits[i] = $urandom_range(maxw, minw);
    hs_log.delete();
    clr_log.delete();
    exp_q.push_back(mk(0, 0, 0, 0, last_idx, last_cnt));
    c = 0;
    exp_lat = N + 2;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(mk(1, 0, 0, 0, i, c));
      if (d[i]) begin
        for (int k = 0; k <= waits[i]; k++) exp_q.push_back(mk(1, 0, 1, 0, i, c));
        c++;
        exp_q.push_back(mk(1, 0, 0, 1, i, c));
        exp_lat += 2 + waits[i];
      end
    end
    exp_q.push_back(mk(1, 1, 0, 0, N - 1, c));
    last_idx = N - 1;
    last_cnt = c;
    load_val  = d;
    load_en   = 1'b1;
    req_pulse = 1'b1;
    lat = -1;
    for (int k = 1; k <= 400 && lat < 0; k++) begin
      @(negedge clk_i);
      if (flush_done_o) lat = k;
      if (k == 1) begin
        @(posedge clk_i); #1;
        load_en   = 1'b0;
        req_pulse = 1'b0;
      end
    end
    if (lat < 0) check_eq("done_timeout", lat, exp_lat);
    wait_drain(60);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, exp_lat, found, clr_before;
    logic [N-1:0] d;

    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_busy", flush_busy_o, 0);
    check_eq("rst_done", flush_done_o, 0);
    check_eq("rst_wbreq", wb_req_o, 0);
    check_eq("rst_clr", dirty_clr_o, 0);
    check_eq("rst_cnt", wb_cnt_o, 0);
    check_eq("rst_raddr", dirty_raddr_o, 0);
    @(negedge clk_i); #2;
    rst_i = 1'b1;
    last_idx = 0;
    last_cnt = 0;
    push_idle(3);

    // all clean
    run_flush(8'h00, 0, 0, lat, exp_lat);
    check_eq("clean_latency", lat, 10);
    check_eq("clean_cnt", wb_cnt_o, 0);
    check_eq("clean_wb_count", hs_log.size(), 0);
    push_idle(2);

    // lines 2 and 7 dirty, ack tied high
    run_flush(8'h84, 0, 0, lat, exp_lat);
    check_eq("d27_latency", lat, 14);
    check_eq("d27_cnt", wb_cnt_o, 2);
    check_eq("d27_wb_count", hs_log.size(), 2);
    if (hs_log.size() == 2) begin
      check_eq("d27_wb_first", hs_log[0], 2);
      check_eq("d27_wb_second", hs_log[1], 7);
    end
    check_eq("d27_clr_count", clr_log.size(), 2);
    if (clr_log.size() == 2) begin
      check_eq("d27_clr_first", clr_log[0], 2);
      check_eq("d27_clr_second", clr_log[1], 7);
    end
    push_idle(2);

    // line 0 dirty, ack held low for 5 cycles
    run_flush(8'h01, 5, 5, lat, exp_lat);
    check_eq("d0_latency", lat, 17);
    check_eq("d0_clr_count", clr_log.size(), 1);
    if (clr_log.size() == 1) check_eq("d0_clr_addr", clr_log[0], 0);
    push_idle(1);

    // every line dirty, ack tied high
    run_flush(8'hFF, 0, 0, lat, exp_lat);
    check_eq("all_latency", lat, 26);
    check_eq("all_cnt", wb_cnt_o, 8);
    check_eq("all_clr_count", clr_log.size(), 8);
    if (clr_log.size() == 8) check_eq("all_clr_last", clr_log[7], 7);
    check_eq("all_mem_clean", dirty_mem, 0);
    push_idle(4);

    // randomized patterns with stray requests and acks
    for (int it = 0; it < 20; it++) begin
      d = N'($urandom);
      noise_en = 1'b1;
      run_flush(d, 0, 3, lat, exp_lat);
      noise_en = 1'b0;
      check_eq("rand_latency", lat, exp_lat);
      check_eq("rand_cnt", wb_cnt_o, $countones(d));
      check_eq("rand_mem_clean", dirty_mem, 0);
      push_idle($urandom_range(3, 1));
    end
    @(negedge clk_i); #1;

    // reset while waiting on the writeback of line 4
    @(posedge clk_i); #1;
    for (int i = 0; i < N; i++) waits[i] = 0;
    waits[4] = 1000;
    clr_log.delete();
    load_val = 8'h10; load_en = 1'b1; req_pulse = 1'b1;
    @(posedge clk_i); #1;
    load_en = 1'b0; req_pulse = 1'b0;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(negedge clk_i);
      if (wb_req_o) found = 1;
    end
    check_eq("abort_reach_wb", found, 1);
    check_eq("abort_wb_addr", wb_addr_o, 4);
    clr_before = clr_log.size();
    #2 rst_i = 1'b0;
    #1;
    check_eq("abort_busy", flush_busy_o, 0);
    check_eq("abort_wbreq", wb_req_o, 0);
    check_eq("abort_clr", dirty_clr_o, 0);
    check_eq("abort_done", flush_done_o, 0);
    check_eq("abort_cnt", wb_cnt_o, 0);
    check_eq("abort_raddr", dirty_raddr_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("abort_no_clear", clr_log.size(), clr_before);
    check_eq("abort_bit4_kept", dirty_mem[4], 1);
    @(negedge clk_i); #2;
    rst_i = 1'b1;
    last_idx = 0;
    last_cnt = 0;
    push_idle(3);
    run_flush(8'h10, 0, 3, lat, exp_lat);
    check_eq("restart_latency", lat, exp_lat);
    check_eq("restart_cnt", wb_cnt_o, 1);
    check_eq("restart_wb_count", hs_log.size(), 1);
    if (hs_log.size() == 1) check_eq("restart_wb_addr", hs_log[0], 4);
    push_idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
